// File: rtl/seg7_pkg.sv
// Shared constants and hex glyph table for the 7-segment scan driver.
// Segment patterns are active-low {G,F,E,D,C,B,A}.
package seg7_pkg;

  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [7:0] AN_OFF    = 8'hFF;

  typedef logic [6:0] seg_pat_t;

  // Entry k is the glyph for hex digit k (lowercase b and d).
  localparam seg_pat_t [15:0] HEX_LUT = {
    7'h0E, 7'h06, 7'h21, 7'h46,
    7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19,
    7'h30, 7'h24, 7'h79, 7'h40
  };

  function automatic seg_pat_t hex_to_seg(input logic [3:0] nib);
    return HEX_LUT[nib];
  endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational nibble to active-low 7-segment pattern.
// Shared by the scan driver on the currently selected digit.
module seg7_hex_decode
  import seg7_pkg::*;
(
  input  logic [3:0] nib,
  output seg_pat_t   seg
);

  assign seg = hex_to_seg(nib);

endmodule

// File: rtl/seg7_scan_driver.sv
// Double-buffered 8-digit common-anode 7-segment scan driver.
// Define SEG7_DEGHOST_EN to blank AN for DEGHOST_CYC cycles per slot.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int DIGITS      = 8,
  parameter int SCAN_DIV    = 100000,
  parameter int DEGHOST_CYC = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] data_in,
  input  logic        load,
  input  logic [7:0]  dp_in,
  output logic        busy,
  output logic [7:0]  AN,
  output logic [7:0]  SEG
);

  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int CW = $clog2(SCAN_DIV);

`ifdef SEG7_DEGHOST_EN
  localparam bit DEGHOST = 1'b1;
`else
  localparam bit DEGHOST = 1'b0;
`endif

  logic [CW-1:0] div_cnt_q, div_cnt_d;
  logic [IW-1:0] dig_idx_q, dig_idx_d;
  logic [31:0]   shadow_q, shadow_d;
  logic [31:0]   pending_q, pending_d;
  logic          busy_q, busy_d;
  logic [7:0]    an_q, an_d;
  logic [7:0]    seg_q, seg_d;

  logic          div_last;
  logic          dig_last;
  logic          frame;
  logic          ghost;
  logic [3:0]    cur_nib;
  seg_pat_t      cur_pat;

  assign cur_nib = shadow_q[{dig_idx_q, 2'b00} +: 4];

  seg7_hex_decode u_dec (
    .nib (cur_nib),
    .seg (cur_pat)
  );

  always_comb begin
    div_last  = (div_cnt_q == CW'(SCAN_DIV - 1));
    dig_last  = (dig_idx_q == IW'(DIGITS - 1));
    frame     = div_last && dig_last;
    ghost     = DEGHOST && (div_cnt_q < CW'(DEGHOST_CYC));

    div_cnt_d = div_last ? '0 : div_cnt_q + CW'(1);
    dig_idx_d = dig_idx_q;
    if (div_last) begin
      dig_idx_d = dig_last ? '0 : dig_idx_q + IW'(1);
    end

    shadow_d  = shadow_q;
    busy_d    = busy_q;
    pending_d = load ? data_in : pending_q;
    // Transfer sees the old pending even if a load lands on the boundary.
    if (frame && busy_q) begin
      shadow_d = pending_q;
      busy_d   = 1'b0;
    end
    if (load) begin
      busy_d = 1'b1;
    end

    an_d  = ghost ? AN_OFF : ~(8'b1 << dig_idx_q);
    seg_d = {~dp_in[dig_idx_q], cur_pat};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt_q <= '0;
      dig_idx_q <= '0;
      shadow_q  <= '0;
      pending_q <= '0;
      busy_q    <= 1'b0;
      an_q      <= AN_OFF;
      seg_q     <= SEG_BLANK;
    end else begin
      div_cnt_q <= div_cnt_d;
      dig_idx_q <= dig_idx_d;
      shadow_q  <= shadow_d;
      pending_q <= pending_d;
      busy_q    <= busy_d;
      an_q      <= an_d;
      seg_q     <= seg_d;
    end
  end

  assign busy = busy_q;
  assign AN   = an_q;
  assign SEG  = seg_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Scoreboard bench for seg7_scan_driver with SCAN_DIV=4, DIGITS=8.
// Expected AN/SEG/busy are queued per cycle and compared at negedge.
module tb_seg7_scan_driver;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] data_in;
  logic        load;
  logic [7:0]  dp_in;
  logic        busy;
  logic [7:0]  AN;
  logic [7:0]  SEG;

  seg7_scan_driver #(
    .DIGITS      (8),
    .SCAN_DIV    (4),
    .DEGHOST_CYC (1)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .data_in (data_in),
    .load    (load),
    .dp_in   (dp_in),
    .busy    (busy),
    .AN      (AN),
    .SEG     (SEG)
  );

  always #5 clk = ~clk;

  logic [7:0] glyph [16] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
  };

  typedef struct packed {
    logic [7:0] an;
    logic [7:0] seg;
    logic       busy;
  } exp_t;

  exp_t        sb_q [$];
  int          n_cmp = 0;
  int          n_err = 0;
  int          cyc   = 0;

  int          c_m;
  logic [31:0] pend_m;
  logic [31:0] shad_m;
  logic        busy_m;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @cyc%0d: got %h want %h", tag, cyc, got, exp);
    end
  endtask

  task automatic tick(input logic r, input logic ld,
                      input logic [31:0] d, input logic [7:0] dp);
    exp_t e;
    exp_t o;
    int   dg;
    logic [3:0] nib;
    rst     = r;
    load    = ld;
    data_in = d;
    dp_in   = dp;
    if (r) begin
      e      = '{an: 8'hFF, seg: 8'hFF, busy: 1'b0};
      c_m    = 0;
      pend_m = '0;
      shad_m = '0;
      busy_m = 1'b0;
    end else begin
      dg    = (c_m / 4) % 8;
      nib   = 4'((shad_m >> (4 * dg)) & 32'hF);
      e.an  = ~(8'h01 << dg);
      e.seg = glyph[nib] & (dp[dg] ? 8'h7F : 8'hFF);
      if ((c_m % 32) == 31 && busy_m) begin
        shad_m = pend_m;
        busy_m = 1'b0;
      end
      if (ld) begin
        pend_m = d;
        busy_m = 1'b1;
      end
      e.busy = busy_m;
      c_m++;
    end
    sb_q.push_back(e);
    @(posedge clk);
    @(negedge clk);
    cyc++;
    o = sb_q.pop_front();
    chk("AN", 32'(AN), 32'(o.an));
    chk("SEG", 32'(SEG), 32'(o.seg));
    chk("BUSY", 32'(busy), 32'(o.busy));
  endtask

  task automatic idle(input int n, input logic [7:0] dp);
    for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 32'h0, dp);
  endtask

  task automatic run_to(input int phase);
    for (int i = 0; i < 40 && (c_m % 32) != phase; i++)
      tick(1'b0, 1'b0, 32'h0, 8'h00);
  endtask

  initial begin
    rst     = 1'b1;
    load    = 1'b0;
    data_in = '0;
    dp_in   = '0;
    c_m     = 0;
    pend_m  = '0;
    shad_m  = '0;
    busy_m  = 1'b0;

    repeat (3) tick(1'b1, 1'b0, 32'h0, 8'h00);
    idle(64, 8'h00);

    run_to(10);
    tick(1'b0, 1'b1, 32'h89ABCDEF, 8'h00);
    idle(70, 8'h00);

    run_to(5);
    tick(1'b0, 1'b1, 32'h11111111, 8'h00);
    run_to(31);
    tick(1'b0, 1'b1, 32'h22222222, 8'h00);
    idle(70, 8'h00);

    idle(32, 8'h01);

    for (int i = 0; i < 40; i++)
      tick(1'b0, 1'b1, $urandom, 8'($urandom));
    idle(70, 8'hA5);

    idle(13, 8'h00);
    tick(1'b0, 1'b1, 32'hDEADBEEF, 8'h00);
    tick(1'b1, 1'b0, 32'h0, 8'h00);
    idle(70, 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
